// File: rtl/draw_line.sv
// Bresenham line rasteriser: walks one segment per go, holding each point on x/y for DWELL cycles.
// Latency: first point two edges after go is accepted; busy for 1+N*DWELL cycles, done in the first idle cycle after.
module draw_line #(
    parameter int OUT_WIDTH = 8,
    parameter int FRAME_MIN = 0,
    parameter int DWELL     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [OUT_WIDTH-1:0] i_start_x,
    input  logic [OUT_WIDTH-1:0] i_start_y,
    input  logic [OUT_WIDTH-1:0] i_end_x,
    input  logic [OUT_WIDTH-1:0] i_end_y,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] x,
    output logic [OUT_WIDTH-1:0] y,
    output logic                 point_valid,
    output logic                 done
);

    localparam int EW  = OUT_WIDTH + 3;
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [OUT_WIDTH-1:0] FMIN = OUT_WIDTH'(FRAME_MIN);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

    state_t                state_q, state_d;
    logic [OUT_WIDTH-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic [OUT_WIDTH-1:0]  ex_q, ex_d, ey_q, ey_d;
    logic signed [EW-1:0]  dx_q, dx_d, dy_q, dy_d;
    logic signed [EW-1:0]  err_q, err_d;
    logic signed [EW-1:0]  e2;
    logic                  negx_q, negx_d, negy_q, negy_d;
    logic [DCW-1:0]        dwell_q, dwell_d;
    logic [OUT_WIDTH-1:0]  x_q, x_d, y_q, y_d;
    logic                  pv_q, pv_d, done_q, done_d, busy_q, busy_d;

    function automatic logic signed [EW-1:0] ext(input logic [OUT_WIDTH-1:0] v);
        return signed'({3'b000, v});
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            negx_q  <= 1'b0;
            negy_q  <= 1'b0;
            dwell_q <= '0;
            x_q     <= FMIN;
            y_q     <= FMIN;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            negx_q  <= negx_d;
            negy_q  <= negy_d;
            dwell_q <= dwell_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pv_q    <= pv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        negx_d  = negx_q;
        negy_d  = negy_q;
        dwell_d = dwell_q;
        x_d     = x_q;
        y_d     = y_q;
        pv_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        e2      = err_q <<< 1;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    cx_d    = i_start_x;
                    cy_d    = i_start_y;
                    ex_d    = i_end_x;
                    ey_d    = i_end_y;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // cx/cy already hold the start point; present it as the first point.
                negx_d  = !(ex_q > cx_q);
                negy_d  = !(ey_q > cy_q);
                dx_d    = (ex_q > cx_q) ? ext(ex_q) - ext(cx_q) : ext(cx_q) - ext(ex_q);
                dy_d    = (ey_q > cy_q) ? ext(cy_q) - ext(ey_q) : ext(ey_q) - ext(cy_q);
                err_d   = dx_d + dy_d;
                x_d     = cx_q;
                y_d     = cy_q;
                pv_d    = 1'b1;
                dwell_d = DWELL_LAST;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - DCW'(1);
                end else if (cx_q == ex_q && cy_q == ey_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (e2 >= dy_q) begin
                        err_d = err_d + dy_q;
                        cx_d  = negx_q ? cx_q - OUT_WIDTH'(1) : cx_q + OUT_WIDTH'(1);
                    end
                    if (e2 <= dx_q) begin
                        err_d = err_d + dx_q;
                        cy_d  = negy_q ? cy_q - OUT_WIDTH'(1) : cy_q + OUT_WIDTH'(1);
                    end
                    x_d     = cx_d;
                    y_d     = cy_d;
                    pv_d    = 1'b1;
                    dwell_d = DWELL_LAST;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = busy_q;
    assign x           = x_q;
    assign y           = y_q;
    assign point_valid = pv_q;
    assign done        = done_q;

endmodule

// File: tb/tb_draw_line.sv
// Two rasterisers (DWELL=1 and DWELL=4) share stimulus; each trace is compared to an integer Bresenham model.
module tb_draw_line;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go  = 1'b0;
    logic [7:0] sx_i = '0, sy_i = '0, ex_i = '0, ey_i = '0;
    logic [7:0] xo [2];
    logic [7:0] yo [2];
    logic       bo [2];
    logic       po [2];
    logic       dn [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bc [2];
    int dc [2];
    int dcyc [2];
    longint pq0 [$];
    longint pq1 [$];
    int mxq [$];
    int myq [$];

    draw_line #(.OUT_WIDTH(8), .FRAME_MIN(0), .DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .go(go),
        .i_start_x(sx_i), .i_start_y(sy_i), .i_end_x(ex_i), .i_end_y(ey_i),
        .busy(bo[0]), .x(xo[0]), .y(yo[0]), .point_valid(po[0]), .done(dn[0])
    );

    draw_line #(.OUT_WIDTH(8), .FRAME_MIN(0), .DWELL(4)) u_d4 (
        .clk(clk), .rst(rst), .go(go),
        .i_start_x(sx_i), .i_start_y(sy_i), .i_end_x(ex_i), .i_end_y(ey_i),
        .busy(bo[1]), .x(xo[1]), .y(yo[1]), .point_valid(po[1]), .done(dn[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint enc(int c, int px, int py);
        return longint'(c) * 65536 + longint'(px) * 256 + longint'(py);
    endfunction

    always @(negedge clk) begin
        if (po[0]) pq0.push_back(enc(cyc, int'(xo[0]), int'(yo[0])));
        if (po[1]) pq1.push_back(enc(cyc, int'(xo[1]), int'(yo[1])));
        for (int d = 0; d < 2; d++) begin
            if (bo[d]) bc[d]++;
            if (dn[d]) begin
                dc[d]++;
                dcyc[d] = cyc;
            end
        end
    end

    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference walk in plain integers: list of every point from start to end.
    task automatic model(int sx, int sy, int ex, int ey);
        int dx, dy, stx, sty, err, e2, px, py;
        dx  = iabs(ex - sx);
        dy  = -iabs(ey - sy);
        stx = (ex > sx) ? 1 : -1;
        sty = (ey > sy) ? 1 : -1;
        err = dx + dy;
        px  = sx;
        py  = sy;
        mxq.delete();
        myq.delete();
        for (int guard = 0; guard < 600; guard++) begin
            mxq.push_back(px);
            myq.push_back(py);
            if (px == ex && py == ey) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; px += stx; end
            if (e2 <= dx) begin err += dx; py += sty; end
        end
    endtask

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            bc[d] = 0;
            dc[d] = 0;
            dcyc[d] = -1;
        end
        pq0.delete();
        pq1.delete();
    endtask

    task automatic check_run(int d, int sx, int sy, int ex, int ey, int acc, int hold, string tag);
        longint q [$];
        int n, dw, per, nform, reps, nbad, idx;
        dw = (d == 0) ? 1 : 4;
        if (d == 0) q = pq0; else q = pq1;
        model(sx, sy, ex, ey);
        n     = mxq.size();
        per   = n * dw + 2;
        nform = ((iabs(ex - sx) > iabs(ey - sy)) ? iabs(ex - sx) : iabs(ey - sy)) + 1;
        reps  = (hold - 1) / per + 1;
        chk($sformatf("%s_d%0d_dones", tag, dw), dc[d], reps);
        chk($sformatf("%s_d%0d_npts", tag, dw), q.size(), reps * nform);
        chk($sformatf("%s_d%0d_busycyc", tag, dw), bc[d], reps * (1 + n * dw));
        chk($sformatf("%s_d%0d_donecyc", tag, dw), dcyc[d], acc + reps * per - 1);
        nbad = 0;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < n; i++) begin
                idx = r * n + i;
                if (idx >= q.size() || q[idx] != enc(acc + r * per + 1 + i * dw, mxq[i], myq[i]))
                    nbad++;
            end
        end
        chk($sformatf("%s_d%0d_badpts", tag, dw), nbad, 0);
        chk($sformatf("%s_d%0d_holdx", tag, dw), longint'(xo[d]), ex);
        chk($sformatf("%s_d%0d_holdy", tag, dw), longint'(yo[d]), ey);
    endtask

    task automatic run_seg(int sx, int sy, int ex, int ey, int hold, bit disturb, string tag);
        int acc;
        bit idle_ok;
        @(posedge clk); #2;
        clear_mon();
        sx_i = 8'(sx); sy_i = 8'(sy); ex_i = 8'(ex); ey_i = 8'(ey);
        go  = 1'b1;
        acc = cyc + 1;
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        go = 1'b0;
        sx_i = 8'($urandom); sy_i = 8'($urandom); ex_i = 8'($urandom); ey_i = 8'($urandom);
        idle_ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            if (!bo[0] && !bo[1]) begin
                idle_ok = 1'b1;
                break;
            end
            // Only ever raise go while both units are mid-segment, where it must be ignored.
            if (disturb && bo[0] && bo[1]) begin
                go   = 1'($urandom_range(0, 1));
                sx_i = 8'($urandom); sy_i = 8'($urandom);
                ex_i = 8'($urandom); ey_i = 8'($urandom);
            end else begin
                go = 1'b0;
            end
        end
        go = 1'b0;
        chk($sformatf("%s_idle", tag), idle_ok, 1);
        repeat (3) @(posedge clk);
        #2;
        check_run(0, sx, sy, ex, ey, acc, hold, tag);
        check_run(1, sx, sy, ex, ey, acc, hold, tag);
    endtask

    initial begin
        int acc;
        clear_mon();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_busy%0d", d), bo[d], 0);
            chk($sformatf("rst_done%0d", d), dn[d], 0);
            chk($sformatf("rst_pv%0d", d), po[d], 0);
            chk($sformatf("rst_x%0d", d), longint'(xo[d]), 0);
            chk($sformatf("rst_y%0d", d), longint'(yo[d]), 0);
        end
        rst = 1'b0;

        run_seg(0, 0, 4, 0, 1, 1'b0, "hline");
        run_seg(10, 10, 7, 17, 1, 1'b0, "steep");
        run_seg(255, 255, 0, 0, 1, 1'b0, "diag");
        run_seg(37, 200, 37, 200, 1, 1'b0, "zero");
        run_seg(0, 0, 20, 5, 1, 1'b1, "disturb");
        run_seg(5, 5, 7, 6, 30, 1'b0, "b2b");

        // Reset when the DWELL=1 unit shows its third point.
        @(posedge clk); #2;
        clear_mon();
        model(0, 0, 20, 5);
        sx_i = 8'd0; sy_i = 8'd0; ex_i = 8'd20; ey_i = 8'd5;
        go  = 1'b1;
        acc = cyc + 1;
        @(posedge clk); #2;
        go = 1'b0;
        while (cyc < acc + 3) begin
            @(posedge clk); #2;
        end
        chk("mid_pv", po[0], 1);
        chk("mid_x", longint'(xo[0]), mxq[2]);
        chk("mid_y", longint'(yo[0]), myq[2]);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst_busy%0d", d), bo[d], 0);
            chk($sformatf("midrst_x%0d", d), longint'(xo[d]), 0);
            chk($sformatf("midrst_y%0d", d), longint'(yo[d]), 0);
        end
        repeat (10) @(posedge clk);
        #2;
        chk("midrst_nodone", dc[0] + dc[1], 0);
        chk("midrst_stayidle", bo[0] | bo[1], 0);
        run_seg(3, 250, 9, 240, 1, 1'b0, "postrst");

        for (int t = 0; t < 6; t++) begin
            run_seg(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    1, t[0], $sformatf("rnd%0d", t));
        end
        for (int t = 0; t < 4; t++) begin
            run_seg(int'($urandom_range(0, 12)), int'($urandom_range(240, 255)),
                    int'($urandom_range(0, 12)), int'($urandom_range(240, 255)),
                    int'($urandom_range(1, 40)), 1'b0, $sformatf("short%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
